hazard_detect_unit: RTL and testbench

- Producer side of the ID-stage hazard interface consumed by the ID/EX pipeline register.
- Detects load-use data hazards and taken-branch/jump control hazards.
- Drives ID_Hazard_lwstall and ID_Hazard_Branch into ID_EX, plus PC/IF_ID write-enables and the IF flush.
- A small FSM extends stalls and flushes over multiple cycles for deeper memory and branch-resolution latencies.

---
 rtl/hazard_detect_unit.sv | 193 +++++++++++++++++++
 tb/tb_hazard_detect_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_detect_unit.sv
// -----------------------------------------------------------------------------
// hazard_detect_unit
//
// ID-stage hazard producer for the ID/EX pipeline register. It detects
// load-use data hazards and taken-branch/jump control hazards. A small FSM
// stretches a stall or flush over several cycles when the memory or
// branch-resolution latency is deeper than one cycle.
//
// Outputs are combinational from the FSM state and the current inputs, so
// ID_EX, PC and IF_ID act on them at the next rising edge.
//
// Parameters:
//   LW_STALL_CYCLES  bubbles per load-use hazard (1..15)
//   BR_FLUSH_CYCLES  flush cycles per taken branch/jump (1..15)
//
// Ports:
//   clk                rising-edge clock
//   rst                synchronous reset, active high
//   ID_EX_MemRead      instruction in EX is a load
//   ID_EX_RegisterRt   destination register of that load
//   IF_ID_RegisterRs   rs of the instruction in ID
//   IF_ID_RegisterRt   rt of the instruction in ID
//   EX_Branch_taken    branch in EX resolved taken
//   EX_Jump            jump in EX
//   ID_Hazard_lwstall  to ID_EX: zero control bits (bubble)
//   ID_Hazard_Branch   to ID_EX: flush ID/EX contents
//   IF_Flush           to IF_ID: flush fetched instruction
//   PC_write           PC update enable
//   IF_ID_write        IF/ID register write enable
//   hazard_busy        FSM is not in IDLE
//
// Optional feature (macro HAZARD_PERF_EN):
//   lw_stall_count     cycles with ID_Hazard_lwstall=1 (saturating)
//   br_flush_count     cycles with ID_Hazard_Branch=1 (saturating)
// -----------------------------------------------------------------------------
module hazard_detect_unit #(
  parameter int unsigned LW_STALL_CYCLES = 32'd1,
  parameter int unsigned BR_FLUSH_CYCLES = 32'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_RegisterRt,
  input  logic [4:0] IF_ID_RegisterRs,
  input  logic [4:0] IF_ID_RegisterRt,
  input  logic       EX_Branch_taken,
  input  logic       EX_Jump,
  output logic       ID_Hazard_lwstall,
  output logic       ID_Hazard_Branch,
  output logic       IF_Flush,
  output logic       PC_write,
  output logic       IF_ID_write,
  output logic       hazard_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] lw_stall_count,
  output logic [31:0] br_flush_count
`endif
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] LW_STALL = 2'd1;
  localparam logic [1:0] BR_FLUSH = 2'd2;

  // Remaining-cycle reload values; the first stall/flush cycle is spent in IDLE.
  localparam logic [3:0] LW_RELOAD = 4'(LW_STALL_CYCLES - 32'd1);
  localparam logic [3:0] BR_RELOAD = 4'(BR_FLUSH_CYCLES - 32'd1);
  localparam bit         LW_MULTI  = (LW_STALL_CYCLES > 32'd1);
  localparam bit         BR_MULTI  = (BR_FLUSH_CYCLES > 32'd1);

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic [3:0] count_r;
  logic [3:0] count_nxt_s;
  logic       lw_hit_s;
  logic       br_hit_s;

  // Hazard terms; register $0 is hardwired zero so it never needs a stall.
  always_comb begin
    lw_hit_s = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
               ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                (ID_EX_RegisterRt == IF_ID_RegisterRt));
    br_hit_s = EX_Branch_taken || EX_Jump;
  end

  // Output decode and next-state logic; branch always beats a pending stall.
  always_comb begin
    ID_Hazard_lwstall = 1'b0;
    ID_Hazard_Branch  = 1'b0;
    IF_Flush          = 1'b0;
    PC_write          = 1'b1;
    IF_ID_write       = 1'b1;
    hazard_busy       = 1'b0;
    state_nxt_s       = state_r;
    count_nxt_s       = count_r;
    if (rst) begin
      state_nxt_s = IDLE;
      count_nxt_s = 4'd0;
    end else begin
      hazard_busy = (state_r != IDLE);
      case (state_r)
        IDLE, LW_STALL: begin
          if (br_hit_s) begin
            ID_Hazard_Branch = 1'b1;
            IF_Flush         = 1'b1;
            if (BR_MULTI) begin
              state_nxt_s = BR_FLUSH;
              count_nxt_s = BR_RELOAD;
            end else begin
              state_nxt_s = IDLE;
              count_nxt_s = 4'd0;
            end
          end else if (state_r == LW_STALL) begin
            // Stall continues regardless of lw_hit until the count expires.
            ID_Hazard_lwstall = 1'b1;
            PC_write          = 1'b0;
            IF_ID_write       = 1'b0;
            if (count_r <= 4'd1) begin
              state_nxt_s = IDLE;
              count_nxt_s = 4'd0;
            end else begin
              count_nxt_s = count_r - 4'd1;
            end
          end else if (lw_hit_s) begin
            ID_Hazard_lwstall = 1'b1;
            PC_write          = 1'b0;
            IF_ID_write       = 1'b0;
            if (LW_MULTI) begin
              state_nxt_s = LW_STALL;
              count_nxt_s = LW_RELOAD;
            end else begin
              state_nxt_s = IDLE;
              count_nxt_s = 4'd0;
            end
          end else begin
            state_nxt_s = IDLE;
            count_nxt_s = 4'd0;
          end
        end
        BR_FLUSH: begin
          // Flush continues; a load-use hit is moot because ID is squashed.
          ID_Hazard_Branch = 1'b1;
          IF_Flush         = 1'b1;
          if (br_hit_s) begin
            count_nxt_s = BR_RELOAD;
          end else if (count_r <= 4'd1) begin
            state_nxt_s = IDLE;
            count_nxt_s = 4'd0;
          end else begin
            count_nxt_s = count_r - 4'd1;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          count_nxt_s = 4'd0;
        end
      endcase
    end
  end

  // FSM state and remaining-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      count_r <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating event counters for stall and flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      lw_stall_count <= 32'd0;
      br_flush_count <= 32'd0;
    end else begin
      if (ID_Hazard_lwstall && (lw_stall_count != 32'hFFFF_FFFF)) begin
        lw_stall_count <= lw_stall_count + 32'd1;
      end else begin
        lw_stall_count <= lw_stall_count;
      end
      if (ID_Hazard_Branch && (br_flush_count != 32'hFFFF_FFFF)) begin
        br_flush_count <= br_flush_count + 32'd1;
      end else begin
        br_flush_count <= br_flush_count;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_detect_unit
//
// Two instances share one stimulus stream: u_a (LW=1, BR=3) and u_b (LW=4,
// BR=1). Each is compared every cycle against a behavioural model that keeps
// "cycles of stall/flush still owed" as plain integers. Directed sequences
// come first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_hazard_detect_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read;
  logic [4:0] ex_rt;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       br_taken;
  logic       jump;

  logic a_lw, a_br, a_fl, a_pc, a_ifid, a_busy;
  logic b_lw, b_br, b_fl, b_pc, b_ifid, b_busy;
  logic [5:0] obs_s [2];

`ifdef HAZARD_PERF_EN
  logic [31:0] a_lwc, a_brc, b_lwc, b_brc;
`endif

  always #5 clk = ~clk;

  hazard_detect_unit #(.LW_STALL_CYCLES(1), .BR_FLUSH_CYCLES(3)) u_a (
    .clk(clk), .rst(rst),
    .ID_EX_MemRead(mem_read), .ID_EX_RegisterRt(ex_rt),
    .IF_ID_RegisterRs(id_rs), .IF_ID_RegisterRt(id_rt),
    .EX_Branch_taken(br_taken), .EX_Jump(jump),
    .ID_Hazard_lwstall(a_lw), .ID_Hazard_Branch(a_br), .IF_Flush(a_fl),
    .PC_write(a_pc), .IF_ID_write(a_ifid), .hazard_busy(a_busy)
`ifdef HAZARD_PERF_EN
    , .lw_stall_count(a_lwc), .br_flush_count(a_brc)
`endif
  );

  hazard_detect_unit #(.LW_STALL_CYCLES(4), .BR_FLUSH_CYCLES(1)) u_b (
    .clk(clk), .rst(rst),
    .ID_EX_MemRead(mem_read), .ID_EX_RegisterRt(ex_rt),
    .IF_ID_RegisterRs(id_rs), .IF_ID_RegisterRt(id_rt),
    .EX_Branch_taken(br_taken), .EX_Jump(jump),
    .ID_Hazard_lwstall(b_lw), .ID_Hazard_Branch(b_br), .IF_Flush(b_fl),
    .PC_write(b_pc), .IF_ID_write(b_ifid), .hazard_busy(b_busy)
`ifdef HAZARD_PERF_EN
    , .lw_stall_count(b_lwc), .br_flush_count(b_brc)
`endif
  );

  assign obs_s[0] = {a_lw, a_br, a_fl, a_pc, a_ifid, a_busy};
  assign obs_s[1] = {b_lw, b_br, b_fl, b_pc, b_ifid, b_busy};

  int n_total = 0;
  int n_bad   = 0;

  // Model state: parameters and cycles still owed per instance.
  int lw_cyc   [2] = '{1, 4};
  int br_cyc   [2] = '{3, 1};
  int lw_left  [2] = '{0, 0};
  int br_left  [2] = '{0, 0};
  logic [31:0] exp_lwc [2] = '{32'd0, 32'd0};
  logic [31:0] exp_brc [2] = '{32'd0, 32'd0};
  string fld_name [6] = '{"lwstall", "branch", "if_flush", "pc_write", "if_id_write", "busy"};

  task automatic check_eq(input string tag, input int idx,
                          input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s u%0d got=%0h expected=%0h t=%0t", tag, idx, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check all outputs against the model, advance it.
  task automatic do_cycle(input logic r, input logic m, input logic [4:0] ert,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic b, input logic j);
    logic       hit_lw;
    logic       hit_br;
    logic       e_lw, e_br, e_busy;
    logic [5:0] exp_v;
    @(negedge clk);
    rst = r; mem_read = m; ex_rt = ert; id_rs = rs; id_rt = rt;
    br_taken = b; jump = j;
    #1;
    hit_lw = m && (ert != 5'd0) && ((ert == rs) || (ert == rt));
    hit_br = b || j;
    for (int i = 0; i < 2; i++) begin
`ifdef HAZARD_PERF_EN
      check_eq("lw_stall_count", i, (i == 0) ? a_lwc : b_lwc, exp_lwc[i]);
      check_eq("br_flush_count", i, (i == 0) ? a_brc : b_brc, exp_brc[i]);
`endif
      e_lw = 1'b0; e_br = 1'b0;
      e_busy = !r && ((lw_left[i] > 0) || (br_left[i] > 0));
      if (r) begin
        lw_left[i] = 0; br_left[i] = 0;
      end else if (hit_br) begin
        e_br = 1'b1; br_left[i] = br_cyc[i] - 1; lw_left[i] = 0;
      end else if (br_left[i] > 0) begin
        e_br = 1'b1; br_left[i]--;
      end else if (lw_left[i] > 0) begin
        e_lw = 1'b1; lw_left[i]--;
      end else if (hit_lw) begin
        e_lw = 1'b1; lw_left[i] = lw_cyc[i] - 1;
      end
      exp_v = {e_lw, e_br, e_br, !e_lw, !e_lw, e_busy};
      for (int k = 0; k < 6; k++) begin
        check_eq(fld_name[k], i, 32'(obs_s[i][5-k]), 32'(exp_v[5-k]));
      end
      if (r) begin
        exp_lwc[i] = 32'd0; exp_brc[i] = 32'd0;
      end else begin
        if (e_lw && exp_lwc[i] != 32'hFFFF_FFFF) exp_lwc[i] = exp_lwc[i] + 32'd1;
        if (e_br && exp_brc[i] != 32'hFFFF_FFFF) exp_brc[i] = exp_brc[i] + 32'd1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) do_cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    br_taken = 1'b0; jump = 1'b0;

    // Reset held with a live load-use hazard, then release.
    do_cycle(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    idle(4);

    // Load-use on rt, then hazard removed.
    do_cycle(1'b0, 1'b1, 5'd8, 5'd0, 5'd8, 1'b0, 1'b0);
    idle(4);

    // Zero register and non-matching registers.
    do_cycle(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b1, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0);

    // Taken branch, then jump.
    do_cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    idle(3);
    do_cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle(3);

    // Branch arriving in stall cycle 2 aborts the stall.
    do_cycle(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0);
    idle(4);

    // Simultaneous branch and load-use: branch wins.
    do_cycle(1'b0, 1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0);
    idle(3);

    // Reset mid-stall leaves no residue.
    do_cycle(1'b0, 1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    idle(4);

    // Five load-use events and two branches, then reset clears counters.
    for (int e = 0; e < 5; e++) begin
      do_cycle(1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0);
      idle(4);
    end
    for (int e = 0; e < 2; e++) begin
      do_cycle(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      idle(3);
    end
    do_cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    idle(2);

    // Randomized traffic with small register numbers so hits are frequent.
    for (int c = 0; c < 3000; c++) begin
      do_cycle(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
               1'($urandom_range(0, 1)),
               5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)),
               ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0,
               ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0);
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
